// File: rtl/corr_cmd_gen.sv
// Command sequencer for the correlator: clear, per-hit index switches, drain, output switch.
// Optional ACCUM idle timeout is built only when CORR_CMD_TIMEOUT_EN is defined.
module corr_cmd_gen #(
    parameter int HIT_GAP        = 2,
    parameter int DRAIN_CYCLES   = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       hit_valid_i,
    input  logic [5:0] hit_addr_i,
    input  logic       hit_last_i,
    output logic       hit_ready_o,
    output logic [5:0] addr_o,
    output logic [1:0] cmd_o,
    output logic       busy_o,
    output logic [7:0] hit_cnt_o,
    output logic       timeout_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ACCUM = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_EMIT  = 3'd5;

    localparam logic [1:0] CMD_HOLD  = 2'b00;
    localparam logic [1:0] CMD_INDEX = 2'b01;
    localparam logic [1:0] CMD_OUT   = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    // The 01 cycle is the first GAP cycle; after a last hit it precedes the full drain window.
    localparam logic [3:0] GAP_LOAD       = 4'(HIT_GAP - 1);
    localparam logic [3:0] DRAIN_LOAD_HIT = 4'(DRAIN_CYCLES);
    localparam logic [3:0] DRAIN_LOAD_TO  = 4'(DRAIN_CYCLES - 1);

    if (HIT_GAP < 1 || HIT_GAP > 15) begin : g_bad_gap
        $error("HIT_GAP out of range 1..15");
    end
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
        $error("DRAIN_CYCLES out of range 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..255");
    end

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] cmd_q, cmd_d;
    logic [5:0] addr_q, addr_d;
    logic [7:0] hit_cnt_q, hit_cnt_d;
`ifdef CORR_CMD_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] idle_q, idle_d;
    logic       timeout_q, timeout_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = CMD_HOLD;
        addr_d    = addr_q;
        hit_cnt_d = hit_cnt_q;
`ifdef CORR_CMD_TIMEOUT_EN
        idle_d    = idle_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_CLEAR;
                    cmd_d     = CMD_CLEAR;
                    addr_d    = 6'd0;
                    hit_cnt_d = 8'd0;
                end
            end
            S_CLEAR: begin
                state_d = S_ACCUM;
`ifdef CORR_CMD_TIMEOUT_EN
                idle_d  = 8'd0;
`endif
            end
            S_ACCUM: begin
                if (hit_valid_i) begin
                    cmd_d  = CMD_INDEX;
                    addr_d = hit_addr_i;
                    if (hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
                    if (hit_last_i) begin
                        state_d = S_DRAIN;
                        cnt_d   = DRAIN_LOAD_HIT;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end
`ifdef CORR_CMD_TIMEOUT_EN
                    idle_d = 8'd0;
                end else if (idle_q == TO_LAST) begin
                    state_d   = S_DRAIN;
                    cnt_d     = DRAIN_LOAD_TO;
                    timeout_d = 1'b1;
                    idle_d    = 8'd0;
                end else begin
                    idle_d = idle_q + 8'd1;
`endif
                end
            end
            S_GAP: begin
                if (cnt_q == 4'd0) state_d = S_ACCUM;
                else cnt_d = cnt_q - 4'd1;
            end
            S_DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_EMIT;
                    cmd_d   = CMD_OUT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_EMIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            cmd_q     <= CMD_HOLD;
            addr_q    <= 6'd0;
            hit_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

`ifdef CORR_CMD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign hit_ready_o = (state_q == S_ACCUM);
    assign busy_o      = (state_q != S_IDLE);
    assign cmd_o       = cmd_q;
    assign addr_o      = addr_q;
    assign hit_cnt_o   = hit_cnt_q;
endmodule
